// File: rtl/ram_slot_mgr.sv
// Slot allocator over a SIZE_RAM-entry occupancy bitmap: lowest-free-index grant, indexed release, flush.
// Optional double-free detection is built when SLOT_MGR_DOUBLE_FREE_CHK_EN is defined.
module ram_slot_mgr #(
  parameter int SIZE_RAM     = 32,
  parameter int SIZE_RAM_LOG = 5
) (
  input  logic                    Clk,
  input  logic                    Rst_n,
  input  logic                    AllocReq,
  output logic                    AllocGnt,
  output logic [SIZE_RAM_LOG-1:0] AllocIdx,
  input  logic                    FreeValid,
  input  logic [SIZE_RAM_LOG-1:0] FreeIdx,
  input  logic                    Flush,
  output logic [SIZE_RAM-1:0]     RamValid,
  output logic [SIZE_RAM_LOG:0]   UsedCount,
  output logic                    Full,
  output logic                    Empty,
  output logic                    ErrDoubleFree
);

  localparam logic [SIZE_RAM_LOG:0] CNT_MAX = (SIZE_RAM_LOG+1)'(SIZE_RAM);
  localparam logic [SIZE_RAM_LOG:0] CNT_ONE = {{SIZE_RAM_LOG{1'b0}}, 1'b1};

  logic [SIZE_RAM-1:0]   ram_valid_reg;
  logic [SIZE_RAM-1:0]   ram_valid_next;
  logic [SIZE_RAM_LOG:0] used_count_reg;
  logic [SIZE_RAM_LOG:0] used_count_next;
  logic [SIZE_RAM-1:0]   set_mask;
  logic [SIZE_RAM-1:0]   clr_mask;
  logic                  free_eff;
  logic                  count_dec;

  assign Full      = (used_count_reg == CNT_MAX);
  assign Empty     = (used_count_reg == '0);
  assign AllocGnt  = AllocReq & ~Full;
  assign RamValid  = ram_valid_reg;
  assign UsedCount = used_count_reg;

  // Descending scan so the lowest clear bit wins; a full bitmap leaves index 0.
  always_comb begin
    AllocIdx = '0;
    for (int i = SIZE_RAM - 1; i >= 0; i--) begin
      if (!ram_valid_reg[i]) AllocIdx = SIZE_RAM_LOG'(i);
    end
  end

  // Per-slot decode; an out-of-range FreeIdx matches no slot and so changes nothing.
  genvar gi;
  generate
    for (gi = 0; gi < SIZE_RAM; gi++) begin : g_slot
      localparam logic [SIZE_RAM_LOG-1:0] SLOT_IDX = SIZE_RAM_LOG'(gi);
      assign set_mask[gi] = AllocGnt && (AllocIdx == SLOT_IDX);
      assign clr_mask[gi] = FreeValid && (FreeIdx == SLOT_IDX);
    end
  endgenerate

`ifdef SLOT_MGR_DOUBLE_FREE_CHK_EN
  logic dbl_free;
  logic err_reg;
  assign free_eff      = |(clr_mask & ram_valid_reg);
  assign dbl_free      = (|clr_mask) & ~free_eff;
  assign ErrDoubleFree = err_reg;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)     err_reg <= 1'b0;
    else if (Flush) err_reg <= 1'b0;
    else            err_reg <= dbl_free;
  end
`else
  assign free_eff      = |clr_mask;
  assign ErrDoubleFree = 1'b0;
`endif

  // Saturate at zero so an unchecked double free cannot wrap the counter.
  assign count_dec      = free_eff && (used_count_reg != '0);
  assign ram_valid_next = (ram_valid_reg & ~clr_mask) | set_mask;

  always_comb begin
    used_count_next = used_count_reg;
    case ({AllocGnt, count_dec})
      2'b10:   used_count_next = used_count_reg + CNT_ONE;
      2'b01:   used_count_next = used_count_reg - CNT_ONE;
      default: used_count_next = used_count_reg;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      ram_valid_reg  <= '0;
      used_count_reg <= '0;
    end else if (Flush) begin
      ram_valid_reg  <= '0;
      used_count_reg <= '0;
    end else begin
      ram_valid_reg  <= ram_valid_next;
      used_count_reg <= used_count_next;
    end
  end

endmodule

// File: tb/tb_ram_slot_mgr.sv
// Directed scoreboard bench for ram_slot_mgr: stimulus queues expected outputs per cycle,
// a negedge monitor pops and compares them against the DUT.
module tb_ram_slot_mgr;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        AllocReq;
  logic        AllocGnt;
  logic [4:0]  AllocIdx;
  logic        FreeValid;
  logic [4:0]  FreeIdx;
  logic        Flush;
  logic [31:0] RamValid;
  logic [5:0]  UsedCount;
  logic        Full;
  logic        Empty;
  logic        ErrDoubleFree;

  typedef struct {
    string       tag;
    logic        gnt;
    logic [4:0]  idx;
    logic [31:0] valid;
    logic [5:0]  cnt;
    logic        full;
    logic        empty;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  ram_slot_mgr #(.SIZE_RAM(32), .SIZE_RAM_LOG(5)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .AllocReq(AllocReq), .AllocGnt(AllocGnt), .AllocIdx(AllocIdx),
    .FreeValid(FreeValid), .FreeIdx(FreeIdx), .Flush(Flush), .RamValid(RamValid),
    .UsedCount(UsedCount), .Full(Full), .Empty(Empty), .ErrDoubleFree(ErrDoubleFree)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input string field, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s.%s: got %0h expected %0h", tag, field, act, exp);
    end
  endtask

  // Monitor: compares one expected record per cycle, mid-cycle.
  always @(negedge Clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check(e.tag, "gnt",   {31'd0, AllocGnt},      {31'd0, e.gnt});
      check(e.tag, "idx",   {27'd0, AllocIdx},      {27'd0, e.idx});
      check(e.tag, "valid", RamValid,               e.valid);
      check(e.tag, "cnt",   {26'd0, UsedCount},     {26'd0, e.cnt});
      check(e.tag, "full",  {31'd0, Full},          {31'd0, e.full});
      check(e.tag, "empty", {31'd0, Empty},         {31'd0, e.empty});
      check(e.tag, "err",   {31'd0, ErrDoubleFree}, {31'd0, e.err});
      $display("txn %s: gnt=%0b idx=%0d valid=%08h cnt=%0d err=%0b",
               e.tag, AllocGnt, AllocIdx, RamValid, UsedCount, ErrDoubleFree);
    end
  end

  task automatic push(input string tag, input logic gnt, input logic [4:0] idx,
                      input logic [31:0] valid, input logic [5:0] cnt, input logic err);
    exp_t e;
    e.tag = tag; e.gnt = gnt; e.idx = idx; e.valid = valid; e.cnt = cnt;
    e.full = (cnt == 6'd32); e.empty = (cnt == 6'd0); e.err = err;
    exp_q.push_back(e);
  endtask

  // Drive one cycle of inputs, queue what the outputs must show during that cycle, advance.
  task automatic cyc(input string tag, input logic req, input logic fv, input logic [4:0] fidx,
                     input logic fl, input logic gnt, input logic [4:0] idx,
                     input logic [31:0] valid, input logic [5:0] cnt, input logic err);
    AllocReq = req; FreeValid = fv; FreeIdx = fidx; Flush = fl;
    push(tag, gnt, idx, valid, cnt, err);
    @(posedge Clk); #1;
  endtask

  function automatic logic [31:0] low_mask(input int n);
    logic [32:0] t;
    t = (33'd1 << n) - 33'd1;
    return t[31:0];
  endfunction

  initial begin
    Rst_n = 1'b0; AllocReq = 1'b0; FreeValid = 1'b0; FreeIdx = 5'd0; Flush = 1'b0;
    repeat (2) @(posedge Clk);
    #1 Rst_n = 1'b1;

    cyc("reset", 0, 0, 0, 0, 0, 0, 32'h0, 0, 0);
    for (int i = 0; i < 32; i++)
      cyc($sformatf("alloc%0d", i), 1, 0, 0, 0, 1, 5'(i), low_mask(i), 6'(i), 0);
    cyc("full_req", 1, 0, 0, 0, 0, 0, 32'hFFFF_FFFF, 32, 0);
    cyc("full_req_free7", 1, 1, 7, 0, 0, 0, 32'hFFFF_FFFF, 32, 0);
    cyc("realloc7", 1, 0, 0, 0, 1, 7, 32'hFFFF_FF7F, 31, 0);
    cyc("flush_full", 0, 0, 0, 1, 0, 0, 32'hFFFF_FFFF, 32, 0);

    for (int i = 0; i < 4; i++)
      cyc($sformatf("fill%0d", i), 1, 0, 0, 0, 1, 5'(i), low_mask(i), 6'(i), 0);
    cyc("alloc_free1", 1, 1, 1, 0, 1, 4, 32'h0000_000F, 4, 0);
    cyc("after_swap", 0, 0, 0, 1, 0, 1, 32'h0000_001D, 4, 0);

    cyc("one_alloc", 1, 0, 0, 0, 1, 0, 32'h0, 0, 0);
`ifdef SLOT_MGR_DOUBLE_FREE_CHK_EN
    cyc("dbl_free3", 0, 1, 3, 0, 0, 1, 32'h1, 1, 0);
    cyc("dbl_err", 0, 0, 0, 0, 0, 1, 32'h1, 1, 1);
    cyc("dbl_err_gone", 0, 0, 0, 1, 0, 1, 32'h1, 1, 0);
`else
    cyc("dbl_free3", 0, 1, 3, 0, 0, 1, 32'h1, 1, 0);
    cyc("dbl_nochk", 0, 0, 0, 0, 0, 1, 32'h1, 0, 0);
    cyc("dbl_nochk2", 0, 0, 0, 1, 0, 1, 32'h1, 0, 0);
`endif

    for (int i = 0; i < 10; i++)
      cyc($sformatf("ten%0d", i), 1, 0, 0, 0, 1, 5'(i), low_mask(i), 6'(i), 0);
    cyc("flush_alloc", 1, 0, 0, 1, 1, 10, 32'h0000_03FF, 10, 0);

    for (int i = 0; i < 5; i++)
      cyc($sformatf("five%0d", i), 1, 0, 0, 0, 1, 5'(i), low_mask(i), 6'(i), 0);
    // Reset dropped mid-cycle with five slots held: outputs must clear before the next edge.
    AllocReq = 1'b0; FreeValid = 1'b0; Flush = 1'b0;
    Rst_n = 1'b0;
    push("async_rst", 0, 0, 32'h0, 0, 0);
    @(posedge Clk); #1;
    cyc("in_reset_req", 1, 0, 0, 0, 1, 0, 32'h0, 0, 0);
    Rst_n = 1'b1;
    cyc("post_rst_alloc", 1, 0, 0, 0, 1, 0, 32'h0, 0, 0);
    cyc("post_rst_idle", 0, 0, 0, 0, 0, 1, 32'h1, 1, 0);

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge Clk);
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
